// File: rtl/hdmi_scaled_video_output.sv
// hdmi_scaled_video_output
//
// Video timing generator and row-buffer pixel fetcher for the HDMI TX
// parallel bus. Generates h/v counters for an arbitrary timing set, fetches
// palette-indexed pixels from the PPU row RAM, resolves them through the
// palette RAM and presents registered RGB with DE/HSYNC/VSYNC. Supports
// horizontal pixel repetition (PIX_REP = 1/2/4), vertical line repetition
// (LINE_REP = 1/2) and selectable sync polarity.
//
// Optional feature: define HDMI_VOUT_TESTPAT_EN to add the test_en input,
// which replaces the palette colours with 8 vertical colour bars while high.
// RAM reads and row-buffer swaps are unaffected by test_en.
//
// Ports:
//   video_clk      in   pixel clock
//   rst_n          in   asynchronous active-low reset
//   test_en        in   colour-bar enable (only with HDMI_VOUT_TESTPAT_EN)
//   vga_pclk       out  copy of video_clk
//   vga_de         out  display enable, aligned with vga_rgb
//   vga_hs         out  horizontal sync (active level HS_POL)
//   vga_vs         out  vertical sync (active level VS_POL)
//   vga_rgb        out  pixel colour {R,G,B}, zero outside DE
//   rowram_rdaddr  out  row-RAM entry address
//   rowram_rddata  in   palette index: [9:1] palette word, [0] half select
//   palram_rdaddr  out  palette RAM 64-bit word address
//   palram_rddata  in   two colours: [23:0] half 0, [55:32] half 1
//   rowram_swap    out  one-cycle pulse asking the PPU to swap row buffers
//   vblank_start   out  one-cycle pulse at first front-porch line, h = 0
//   vblank_end     out  one-cycle pulse one line before first active line
//
// FSM states:
//   state   | meaning
//   IDLE    | outside the fetch window of the line
//   SWAP    | one cycle: optional row swap, reset fetch address/rep count
//   PRE     | wait for the fetch start (HDS-5)
//   DISPLAY | fetching row-RAM entries for the active part of the line

module hdmi_scaled_video_output #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int PIX_REP   = 2,
    parameter int LINE_REP  = 2,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int SWAP_LEAD = 6
) (
    input  logic        video_clk,
    input  logic        rst_n,
`ifdef HDMI_VOUT_TESTPAT_EN
    input  logic        test_en,
`endif
    output logic        vga_pclk,
    output logic        vga_de,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [23:0] vga_rgb,
    output logic [8:0]  rowram_rdaddr,
    input  logic [9:0]  rowram_rddata,
    output logic [8:0]  palram_rdaddr,
    input  logic [63:0] palram_rddata,
    output logic        rowram_swap,
    output logic        vblank_start,
    output logic        vblank_end
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int HDS     = H_SYNC + H_BACK;
    localparam int VDS     = V_SYNC + V_BACK;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_DS       = HW'(HDS);
    localparam logic [HW-1:0] H_DE       = HW'(HDS + H_VISIBLE);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    // IDLE leaves one cycle early so that SWAP itself (and the swap pulse)
    // lands exactly SWAP_LEAD cycles before the first active pixel.
    localparam logic [HW-1:0] H_SWAP     = HW'(HDS - SWAP_LEAD - 1);
    // Fetch starts 4 cycles before pixel 0 to cover the read pipeline.
    localparam logic [HW-1:0] H_PRE_END  = HW'(HDS - 5);
    localparam logic [HW-1:0] H_DISP_END = HW'(HDS + H_VISIBLE - 1);

    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_DS       = VW'(VDS);
    localparam logic [VW-1:0] V_DE       = VW'(VDS + V_VISIBLE);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_VBE      = VW'(VDS - 1);
    localparam bit            V_DS_PAR   = 1'(VDS % 2);

    localparam logic [8:0]    RA_MAX     = 9'(H_VISIBLE / PIX_REP - 1);
    localparam logic [1:0]    REP_LAST   = 2'(PIX_REP - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SWAP    = 2'd1,
        PRE     = 2'd2,
        DISPLAY = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            swap_next;

    logic [HW-1:0]   h_count;
    logic [VW-1:0]   v_count;
    logic [HW-1:0]   h_next;
    logic [VW-1:0]   v_next;
    logic            line_active;
    logic            swap_ok;
    logic            de_next;

    logic [1:0]      rep_cnt;
    logic            half_d1;
    logic            half_d2;
    logic [23:0]     pal_pix;
    logic [23:0]     pix_sel;
    logic            unused_pal;

    assign vga_pclk = video_clk;

    // Upper byte of each palette half carries no colour.
    assign unused_pal = ^{palram_rddata[63:56], palram_rddata[31:24]};

    // ------------------------------------------------------------------
    // Frame counters
    // ------------------------------------------------------------------
    always_comb begin
        h_next = (h_count == H_LAST) ? '0 : h_count + 1'b1;
        v_next = v_count;
        if (h_count == H_LAST) begin
            v_next = (v_count == V_LAST) ? '0 : v_count + 1'b1;
        end
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_count <= '0;
            v_count <= '0;
        end else begin
            h_count <= h_next;
            v_count <= v_next;
        end
    end

    assign line_active = (v_count >= V_DS) && (v_count < V_DE);
    // Swap on even line indices (v - VDS) only when lines are repeated.
    assign swap_ok     = (LINE_REP == 1) || (v_count[0] == V_DS_PAR);
    assign de_next     = (h_next >= H_DS) && (h_next < H_DE) &&
                         (v_next >= V_DS) && (v_next < V_DE);

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        swap_next  = 1'b0;
        case (state)
            IDLE: begin
                if (line_active && (h_count == H_SWAP)) begin
                    state_next = SWAP;
                    swap_next  = swap_ok;
                end
            end
            SWAP: begin
                // With the minimum lead the fetch start is the very next cycle.
                state_next = (h_count == H_PRE_END) ? DISPLAY : PRE;
            end
            PRE: begin
                if (h_count == H_PRE_END) begin
                    state_next = DISPLAY;
                end
            end
            DISPLAY: begin
                if (h_count == H_DISP_END) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            rowram_swap   <= 1'b0;
            rowram_rdaddr <= '0;
            rep_cnt       <= '0;
        end else begin
            rowram_swap <= swap_next;
            if (state == SWAP) begin
                rowram_rdaddr <= '0;
                rep_cnt       <= '0;
            end else if (state == DISPLAY) begin
                if (rep_cnt == REP_LAST) begin
                    rep_cnt <= '0;
                    if (rowram_rdaddr != RA_MAX) begin
                        rowram_rdaddr <= rowram_rdaddr + 1'b1;
                    end
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline: rdaddr(t) -> rddata(t+1) -> palram_rdaddr(t+2)
    //                 -> palram_rddata(t+3) -> vga_rgb(t+4)
    // ------------------------------------------------------------------
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            palram_rdaddr <= '0;
            half_d1       <= 1'b0;
            half_d2       <= 1'b0;
        end else begin
            palram_rdaddr <= rowram_rddata[9:1];
            half_d1       <= rowram_rddata[0];
            half_d2       <= half_d1;
        end
    end

    assign pal_pix = half_d2 ? palram_rddata[55:32] : palram_rddata[23:0];

`ifdef HDMI_VOUT_TESTPAT_EN
    localparam int BAR_W = H_VISIBLE / 8;

    logic [HW-1:0] x_next;
    logic [2:0]    bar;
    logic [23:0]   bar_color;

    always_comb begin
        x_next = h_next - H_DS;
        bar    = '0;
        for (int k = 1; k < 8; k++) begin
            if (x_next >= HW'(k * BAR_W)) begin
                bar = 3'(k);
            end
        end
        case (bar)
            3'd0:    bar_color = 24'hFFFFFF;
            3'd1:    bar_color = 24'hFFFF00;
            3'd2:    bar_color = 24'h00FFFF;
            3'd3:    bar_color = 24'h00FF00;
            3'd4:    bar_color = 24'hFF00FF;
            3'd5:    bar_color = 24'hFF0000;
            3'd6:    bar_color = 24'h0000FF;
            default: bar_color = 24'h000000;
        endcase
    end

    assign pix_sel = test_en ? bar_color : pal_pix;
`else
    assign pix_sel = pal_pix;
`endif

    // ------------------------------------------------------------------
    // Output registers: timing signals are computed from the next counter
    // values so they line up with the counter in the cycle they appear.
    // ------------------------------------------------------------------
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_de       <= 1'b0;
            vga_hs       <= HS_POL;
            vga_vs       <= VS_POL;
            vga_rgb      <= '0;
            vblank_start <= 1'b0;
            vblank_end   <= 1'b0;
        end else begin
            vga_de       <= de_next;
            vga_hs       <= (h_next < H_SYNC_END) ? HS_POL : ~HS_POL;
            vga_vs       <= (v_next < V_SYNC_END) ? VS_POL : ~VS_POL;
            vga_rgb      <= de_next ? pix_sel : '0;
            vblank_start <= (h_next == '0) && (v_next == V_DE);
            vblank_end   <= (h_next == '0) && (v_next == V_VBE);
        end
    end

endmodule

// File: tb/tb_hdmi_scaled_video_output.sv
module tb_hdmi_scaled_video_output;

    // Reduced timing set so several frames fit in a short run.
    localparam int HV = 64, HF = 4, HSY = 8, HB = 8;
    localparam int VV = 16, VF = 2, VSY = 2, VB = 3;
    localparam int HT = HV + HF + HSY + HB;
    localparam int VT = VV + VF + VSY + VB;
    localparam int HDS = HSY + HB;
    localparam int VDS = VSY + VB;
    localparam int FRAME = HT * VT;

    localparam int PR_A = 2, LR_A = 2, SL_A = 6;
    localparam bit HSP_A = 1'b0, VSP_A = 1'b0;
    localparam int PR_B = 4, LR_B = 1, SL_B = 7;
    localparam bit HSP_B = 1'b1, VSP_B = 1'b1;

    logic clk;
    logic rst_n;

    logic        pclk_a, de_a, hs_a, vs_a, swap_a, vbs_a, vbe_a;
    logic [23:0] rgb_a;
    logic [8:0]  ra_a, pa_a;
    logic [9:0]  rd_a;
    logic [63:0] pd_a;

    logic        pclk_b, de_b, hs_b, vs_b, swap_b, vbs_b, vbe_b;
    logic [23:0] rgb_b;
    logic [8:0]  ra_b, pa_b;
    logic [9:0]  rd_b;
    logic [63:0] pd_b;

    logic [9:0]  row_a [0:511];
    logic [9:0]  row_b [0:511];
    logic [63:0] pal   [0:511];

    int cyc;
    int n_assert = 0;
    int n_fail   = 0;
    int swaps_a = 0, swaps_b = 0, de_cnt_a = 0, de_cnt_b = 0, vbs_cnt = 0, vbe_cnt = 0;
    bit rand_mode = 1'b0;
    logic [23:0] q_a[$];
    logic [23:0] q_b[$];

    hdmi_scaled_video_output #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .PIX_REP(PR_A), .LINE_REP(LR_A), .HS_POL(HSP_A), .VS_POL(VSP_A),
        .SWAP_LEAD(SL_A)
    ) dut_a (
        .video_clk(clk), .rst_n(rst_n), .vga_pclk(pclk_a), .vga_de(de_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .vga_rgb(rgb_a),
        .rowram_rdaddr(ra_a), .rowram_rddata(rd_a),
        .palram_rdaddr(pa_a), .palram_rddata(pd_a),
        .rowram_swap(swap_a), .vblank_start(vbs_a), .vblank_end(vbe_a)
    );

    hdmi_scaled_video_output #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .PIX_REP(PR_B), .LINE_REP(LR_B), .HS_POL(HSP_B), .VS_POL(VSP_B),
        .SWAP_LEAD(SL_B)
    ) dut_b (
        .video_clk(clk), .rst_n(rst_n), .vga_pclk(pclk_b), .vga_de(de_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_rgb(rgb_b),
        .rowram_rdaddr(ra_b), .rowram_rddata(rd_b),
        .palram_rdaddr(pa_b), .palram_rddata(pd_b),
        .rowram_swap(swap_b), .vblank_start(vbs_b), .vblank_end(vbe_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read RAM models (row RAM and palette RAM)
    always @(posedge clk) begin
        rd_a <= row_a[ra_a];
        rd_b <= row_b[ra_b];
        pd_a <= pal[pa_a];
        pd_b <= pal[pa_b];
    end

    // Cycles since reset release: frame position is cyc mod HT / VT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] exp_pix(input int x, input int pr, input bit is_b);
        logic [9:0]  e;
        logic [63:0] w;
        e = is_b ? row_b[x / pr] : row_a[x / pr];
        w = pal[e[9:1]];
        return e[0] ? w[55:32] : w[23:0];
    endfunction

    task automatic check_ctl(input string nm, input int pr, input int lr, input int sl,
                             input bit hsp, input bit vsp,
                             input logic de, input logic hs, input logic vs,
                             input logic [8:0] ra, input logic swap,
                             input logic vbs, input logic vbe,
                             input int h, input int v);
        bit act_line;
        int ea;
        act_line = (v >= VDS) && (v < VDS + VV);
        chk({nm, "_de"}, de, act_line && h >= HDS && h < HDS + HV);
        chk({nm, "_hs"}, hs, (h < HSY) ? hsp : !hsp);
        chk({nm, "_vs"}, vs, (v < VSY) ? vsp : !vsp);
        chk({nm, "_swap"}, swap, act_line && h == HDS - sl && ((v - VDS) % lr == 0));
        chk({nm, "_vblank_start"}, vbs, h == 0 && v == VDS + VV);
        chk({nm, "_vblank_end"}, vbe, h == 0 && v == VDS - 1);
        if (act_line && h >= HDS - 4 && h <= HDS + HV + 3) begin
            ea = (h - HDS + 4) / pr;
            if (ea > HV / pr - 1) ea = HV / pr - 1;
            chk({nm, "_rowram_rdaddr"}, ra, ea);
        end
    endtask

    // Monitor / scoreboard, plus the PPU-side row refill on swap.
    always @(negedge clk) begin
        int h, v;
        logic [23:0] e;
        h = cyc % HT;
        v = (cyc / HT) % VT;

        check_ctl("a", PR_A, LR_A, SL_A, HSP_A, VSP_A, de_a, hs_a, vs_a, ra_a,
                  swap_a, vbs_a, vbe_a, h, v);
        check_ctl("b", PR_B, LR_B, SL_B, HSP_B, VSP_B, de_b, hs_b, vs_b, ra_b,
                  swap_b, vbs_b, vbe_b, h, v);

        if (de_a) begin
            de_cnt_a++;
            if (q_a.size() == 0) begin
                n_assert++; n_fail++;
                $display("FAIL a_rgb_underflow: got pixel %0h expected none (cyc %0d)", rgb_a, cyc);
            end else begin
                e = q_a.pop_front();
                chk("a_rgb", rgb_a, e);
            end
        end else begin
            chk("a_rgb_blank", rgb_a, 24'h0);
        end

        if (de_b) begin
            de_cnt_b++;
            if (q_b.size() == 0) begin
                n_assert++; n_fail++;
                $display("FAIL b_rgb_underflow: got pixel %0h expected none (cyc %0d)", rgb_b, cyc);
            end else begin
                e = q_b.pop_front();
                chk("b_rgb", rgb_b, e);
            end
        end else begin
            chk("b_rgb_blank", rgb_b, 24'h0);
        end

        if (swap_a) begin
            swaps_a++;
            for (int k = 0; k < 512; k++) row_a[k] = rand_mode ? 10'($urandom) : 10'(k);
        end
        if (swap_b) begin
            swaps_b++;
            for (int k = 0; k < 512; k++) row_b[k] = rand_mode ? 10'($urandom) : 10'(k);
        end
        if (vbs_a) vbs_cnt++;
        if (vbe_a) vbe_cnt++;

        // Expected pixels for this line, after any swap has refilled the row.
        if (v >= VDS && v < VDS + VV && h == HDS - 2) begin
            for (int x = 0; x < HV; x++) begin
                q_a.push_back(exp_pix(x, PR_A, 1'b0));
                q_b.push_back(exp_pix(x, PR_B, 1'b1));
            end
        end
    end

    initial begin
        bit found;
        rst_n = 1'b0;
        for (int k = 0; k < 512; k++) begin
            row_a[k] = 10'(k);
            row_b[k] = 10'(k);
            pal[k]   = {8'h0, 24'(2 * k + 1), 8'h0, 24'(2 * k)};
        end
        repeat (4) @(negedge clk);
        chk("rst_de", de_a, 1'b0);
        chk("rst_hs_b", hs_b, 1'b1);
        #2 rst_n = 1'b1;

        @(posedge clk);
        #1 chk("pclk_follows_clk", pclk_a, 1'b1);

        // Two frames with identity row / formula palette, then summary counts.
        repeat (2 * FRAME - 1) @(negedge clk);
        chk("f12_swaps_a", swaps_a, 2 * VV / LR_A);
        chk("f12_swaps_b", swaps_b, 2 * VV / LR_B);
        chk("f12_de_cycles_a", de_cnt_a, 2 * VV * HV);
        chk("f12_de_cycles_b", de_cnt_b, 2 * VV * HV);
        chk("f12_vblank_start_cnt", vbs_cnt, 2);
        chk("f12_vblank_end_cnt", vbe_cnt, 2);

        // Reset in the middle of an active line.
        found = 1'b0;
        for (int i = 0; i < FRAME && !found; i++) begin
            @(negedge clk);
            if (cyc % HT == 40 && (cyc / HT) % VT == 10) found = 1'b1;
        end
        chk("reach_midline", found, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_de_a", de_a, 1'b0);
        chk("mid_rst_rgb_a", rgb_a, 24'h0);
        chk("mid_rst_hs_a", hs_a, HSP_A);
        chk("mid_rst_vs_a", vs_a, VSP_A);
        chk("mid_rst_rdaddr_a", ra_a, 9'h0);
        chk("mid_rst_paladdr_a", pa_a, 9'h0);
        chk("mid_rst_swap_a", swap_a, 1'b0);
        chk("mid_rst_de_b", de_b, 1'b0);
        chk("mid_rst_rgb_b", rgb_b, 24'h0);
        chk("mid_rst_hs_b", hs_b, HSP_B);
        chk("mid_rst_vs_b", vs_b, VSP_B);
        chk("mid_rst_rdaddr_b", ra_b, 9'h0);
        q_a.delete();
        q_b.delete();

        // Random palette and random row contents from here on.
        rand_mode = 1'b1;
        for (int k = 0; k < 512; k++) pal[k] = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        #2;
        swaps_a = 0; swaps_b = 0; de_cnt_a = 0; de_cnt_b = 0; vbs_cnt = 0; vbe_cnt = 0;
        rst_n = 1'b1;

        found = 1'b0;
        for (int i = 0; i < FRAME && !found; i++) begin
            @(negedge clk);
            found = vbe_a;
        end
        chk("post_rst_vblank_end_seen", found, 1'b1);
        chk("post_rst_vblank_end_cyc", cyc, (VDS - 1) * HT);

        repeat (2 * FRAME - (VDS - 1) * HT) @(negedge clk);
        chk("f34_swaps_a", swaps_a, 2 * VV / LR_A);
        chk("f34_swaps_b", swaps_b, 2 * VV / LR_B);
        chk("f34_de_cycles_a", de_cnt_a, 2 * VV * HV);
        chk("f34_de_cycles_b", de_cnt_b, 2 * VV * HV);
        chk("f34_vblank_start_cnt", vbs_cnt, 2);
        chk("queue_a_drained", q_a.size(), 0);
        chk("queue_b_drained", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
